// File: rtl/cbfp_min_tree_acc.sv
// -----------------------------------------------------------------------------
// cbfp_min_tree_acc
// Leading-zero-count minimum reducer for the CBFP (block floating point) FFT
// stages. Each beat, NUM_IN LZC lanes are reduced through a pipelined binary
// min tree. The running minimum is then accumulated over a multi-beat block,
// and one registered result is emitted per block.
//
// Optional feature, macro CBFP_MIN_ARGMIN_EN:
//   defined   - the lane and beat (0-based) of the block minimum are tracked
//               and reported on arg_lane / arg_beat.
//   undefined - no index logic is built; arg_lane / arg_beat read 0.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   en         global advance enable; low freezes every register
//   in_valid   beat valid
//   in_last    last beat of block (qualified by in_valid)
//   min_in     NUM_IN lanes of LZC_WIDTH-bit LZC values
//   out_valid  one-cycle (en-qualified) block result strobe
//   min_out    block minimum LZC
//   beat_cnt   number of beats in the reported block
//   out_ovf    block was closed by reaching MAX_BEATS rather than by in_last
//   arg_lane   lane of the winning value
//   arg_beat   beat of the winning value
// -----------------------------------------------------------------------------
module cbfp_min_tree_acc #(
   parameter  int LZC_WIDTH  = 5,
   parameter  int NUM_IN     = 8,
   parameter  int PIPE_EVERY = 2,
   parameter  int MAX_BEATS  = 16,
   localparam int LANE_W     = $clog2(NUM_IN),
   localparam int CNT_W      = $clog2(MAX_BEATS + 1),
   localparam int BEAT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [LZC_WIDTH-1:0] min_in [NUM_IN],
   output logic                 out_valid,
   output logic [LZC_WIDTH-1:0] min_out,
   output logic [CNT_W-1:0]     beat_cnt,
   output logic                 out_ovf,
   output logic [LANE_W-1:0]    arg_lane,
   output logic [BEAT_W-1:0]    arg_beat
);

   localparam int L = $clog2(NUM_IN);

   localparam logic [0:0] S_IDLE = 1'b0;   // no partial block open
   localparam logic [0:0] S_ACC  = 1'b1;   // partial block open

   // ---------------------------------------------------------------------------
   // Min tree. Level 0 is the input lanes; level gl holds NUM_IN>>gl nodes.
   // A level is registered when it is a multiple of PIPE_EVERY and is not the
   // final level. Valid/last ride along with the data through every register.
   // ---------------------------------------------------------------------------
   for (genvar gl = 0; gl <= L; gl++) begin : g_lvl
      localparam int N = NUM_IN >> gl;
      logic [LZC_WIDTH-1:0] w_val [N];
`ifdef CBFP_MIN_ARGMIN_EN
      logic [LANE_W-1:0]    w_lane [N];
`endif
      logic                 w_vld;
      logic                 w_last;

      if (gl == 0) begin : g_src
         for (genvar gj = 0; gj < N; gj++) begin : g_lane
            assign w_val[gj]  = min_in[gj];
`ifdef CBFP_MIN_ARGMIN_EN
            assign w_lane[gj] = LANE_W'(gj);
`endif
         end
         assign w_vld  = in_valid;
         assign w_last = in_last;
      end else begin : g_node
         localparam bit IS_REG = ((gl % PIPE_EVERY) == 0) && (gl < L);

         for (genvar gj = 0; gj < N; gj++) begin : g_cmp
            logic [LZC_WIDTH-1:0] w_a, w_b, w_min;
            logic                 w_sel_b;
            assign w_a     = g_lvl[gl-1].w_val[2*gj];
            assign w_b     = g_lvl[gl-1].w_val[2*gj+1];
            // Strict compare: on a tie the lower-lane operand (a) wins.
            assign w_sel_b = (w_b < w_a);
            assign w_min   = w_sel_b ? w_b : w_a;
`ifdef CBFP_MIN_ARGMIN_EN
            logic [LANE_W-1:0] w_lmin;
            assign w_lmin = w_sel_b ? g_lvl[gl-1].w_lane[2*gj+1]
                                    : g_lvl[gl-1].w_lane[2*gj];
`endif
            if (IS_REG) begin : g_reg
               logic [LZC_WIDTH-1:0] r_min;
`ifdef CBFP_MIN_ARGMIN_EN
               logic [LANE_W-1:0]    r_lane;
`endif
               // NOTE: non-blocking assignments in every clocked block, so all
               // registers sample pre-edge values regardless of block order.
               always_ff @(posedge clk or negedge rstn) begin
                  if (!rstn) begin
                     r_min  <= '0;
`ifdef CBFP_MIN_ARGMIN_EN
                     r_lane <= '0;
`endif
                  end else if (en) begin
                     r_min  <= w_min;
`ifdef CBFP_MIN_ARGMIN_EN
                     r_lane <= w_lmin;
`endif
                  end
               end
               assign w_val[gj]  = r_min;
`ifdef CBFP_MIN_ARGMIN_EN
               assign w_lane[gj] = r_lane;
`endif
            end else begin : g_comb
               assign w_val[gj]  = w_min;
`ifdef CBFP_MIN_ARGMIN_EN
               assign w_lane[gj] = w_lmin;
`endif
            end
         end

         if (IS_REG) begin : g_ctl_reg
            logic r_vld, r_last;
            always_ff @(posedge clk or negedge rstn) begin
               if (!rstn) begin
                  r_vld  <= 1'b0;
                  r_last <= 1'b0;
               end else if (en) begin
                  r_vld  <= g_lvl[gl-1].w_vld;
                  r_last <= g_lvl[gl-1].w_last;
               end
            end
            assign w_vld  = r_vld;
            assign w_last = r_last;
         end else begin : g_ctl_comb
            assign w_vld  = g_lvl[gl-1].w_vld;
            assign w_last = g_lvl[gl-1].w_last;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Block accumulator
   // ---------------------------------------------------------------------------
   logic [LZC_WIDTH-1:0] w_beat_min, w_next_acc;
   logic                 w_beat_vld, w_beat_last;
   logic                 w_take_new, w_forced, w_close;
   logic [CNT_W-1:0]     w_next_cnt;

   logic [0:0]           r_state;
   logic [LZC_WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_out_valid;
   logic [LZC_WIDTH-1:0] r_min_out;
   logic [CNT_W-1:0]     r_beat_cnt;
   logic                 r_ovf;

   assign w_beat_min  = g_lvl[L].w_val[0];
   assign w_beat_vld  = g_lvl[L].w_vld;
   assign w_beat_last = g_lvl[L].w_last;

   // A fresh block always takes the beat; an open block keeps acc on ties so
   // the earliest beat holding the minimum is the one reported.
   assign w_take_new = (r_state == S_IDLE) || (w_beat_min < r_acc);
   assign w_next_acc = w_take_new ? w_beat_min : r_acc;
   assign w_next_cnt = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
   assign w_forced   = !w_beat_last && (w_next_cnt == CNT_W'(MAX_BEATS));
   assign w_close    = w_beat_vld && (w_beat_last || w_forced);

   // NOTE: every register, outputs included, clears on the asynchronous reset,
   // so an open partial block is dropped and the outputs read 0 at once.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_min_out   <= '0;
         r_beat_cnt  <= '0;
         r_ovf       <= 1'b0;
      end else if (en) begin
         r_out_valid <= w_close;
         if (w_beat_vld) begin
            if (w_close) begin
               r_state    <= S_IDLE;
               r_min_out  <= w_next_acc;
               r_beat_cnt <= w_next_cnt;
               r_ovf      <= w_forced;
            end else begin
               r_state <= S_ACC;
               r_acc   <= w_next_acc;
               r_cnt   <= w_next_cnt;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign min_out   = r_min_out;
   assign beat_cnt  = r_beat_cnt;
   assign out_ovf   = r_ovf;

`ifdef CBFP_MIN_ARGMIN_EN
   logic [LANE_W-1:0] w_next_lane, r_acc_lane, r_arg_lane;
   logic [BEAT_W-1:0] w_next_beat, r_acc_beat, r_arg_beat;

   // In an open block r_cnt equals the 0-based index of the current beat.
   assign w_next_lane = w_take_new ? g_lvl[L].w_lane[0] : r_acc_lane;
   assign w_next_beat = (r_state == S_IDLE) ? '0
                      : (w_take_new ? BEAT_W'(r_cnt) : r_acc_beat);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_acc_lane <= '0;
         r_acc_beat <= '0;
         r_arg_lane <= '0;
         r_arg_beat <= '0;
      end else if (en && w_beat_vld) begin
         if (w_close) begin
            r_arg_lane <= w_next_lane;
            r_arg_beat <= w_next_beat;
         end else begin
            r_acc_lane <= w_next_lane;
            r_acc_beat <= w_next_beat;
         end
      end
   end

   assign arg_lane = r_arg_lane;
   assign arg_beat = r_arg_beat;
`else
   assign arg_lane = '0;
   assign arg_beat = '0;
`endif

endmodule

// File: tb/tb_cbfp_min_tree_acc.sv
// -----------------------------------------------------------------------------
// tb_cbfp_min_tree_acc
// Two instances: dut_a (NUM_IN=8, PIPE_EVERY=2, MAX_BEATS=4, one tree register)
// for directed block scenarios, dut_b (NUM_IN=16, PIPE_EVERY=1, MAX_BEATS=16,
// three tree registers) for random back-to-back blocks. Expected block results
// are queued when the closing beat is driven and compared when out_valid is
// seen on an en=1 cycle.
// -----------------------------------------------------------------------------
module tb_cbfp_min_tree_acc;

   localparam int W    = 5;
   localparam int NA   = 8;
   localparam int MAXA = 4;
   localparam int TA   = 1;
   localparam int NB   = 16;
   localparam int MAXB = 16;
   localparam int TB   = 3;

   typedef struct {
      int mn;
      int cnt;
      int ovf;
      int at;
      int lane;
      int beat;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // dut_a signals
   logic         en_a, in_valid_a, in_last_a;
   logic [W-1:0] min_a [NA];
   logic         out_valid_a, out_ovf_a;
   logic [W-1:0] min_out_a;
   logic [2:0]   beat_cnt_a;
   logic [2:0]   arg_lane_a;
   logic [1:0]   arg_beat_a;

   // dut_b signals
   logic         en_b, in_valid_b, in_last_b;
   logic [W-1:0] min_b [NB];
   logic         out_valid_b, out_ovf_b;
   logic [W-1:0] min_out_b;
   logic [4:0]   beat_cnt_b;
   logic [3:0]   arg_lane_b;
   logic [3:0]   arg_beat_b;

   cbfp_min_tree_acc #(.LZC_WIDTH(W), .NUM_IN(NA), .PIPE_EVERY(2), .MAX_BEATS(MAXA)) dut_a (
      .clk(clk), .rstn(rstn), .en(en_a), .in_valid(in_valid_a), .in_last(in_last_a),
      .min_in(min_a), .out_valid(out_valid_a), .min_out(min_out_a), .beat_cnt(beat_cnt_a),
      .out_ovf(out_ovf_a), .arg_lane(arg_lane_a), .arg_beat(arg_beat_a));

   cbfp_min_tree_acc #(.LZC_WIDTH(W), .NUM_IN(NB), .PIPE_EVERY(1), .MAX_BEATS(MAXB)) dut_b (
      .clk(clk), .rstn(rstn), .en(en_b), .in_valid(in_valid_b), .in_last(in_last_b),
      .min_in(min_b), .out_valid(out_valid_b), .min_out(min_out_b), .beat_cnt(beat_cnt_b),
      .out_ovf(out_ovf_b), .arg_lane(arg_lane_b), .arg_beat(arg_beat_b));

   int   n_checks = 0;
   int   n_errors = 0;
   int   ecnt_a   = 0;   // en=1 rising edges seen by dut_a
   int   ecnt_b   = 0;
   exp_t q_a [$];
   exp_t q_b [$];

   logic [W-1:0] lanes_a [NA];
   logic [W-1:0] lanes_b [NB];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (en_a) ecnt_a <= ecnt_a + 1;
      if (en_b) ecnt_b <= ecnt_b + 1;
   end

   // Result monitors: consume a pulse on the cycle the consumer would (en=1).
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rstn && en_a && out_valid_a) begin
         if (q_a.size() == 0) begin
            check("a_spurious_valid", out_valid_a, 0);
         end else begin
            e = q_a.pop_front();
            check("a_min_out",  min_out_a,  e.mn);
            check("a_beat_cnt", beat_cnt_a, e.cnt);
            check("a_out_ovf",  out_ovf_a,  e.ovf);
            check("a_latency",  ecnt_a,     e.at);
`ifdef CBFP_MIN_ARGMIN_EN
            check("a_arg_lane", arg_lane_a, e.lane);
            check("a_arg_beat", arg_beat_a, e.beat);
`else
            check("a_arg_lane", arg_lane_a, 0);
            check("a_arg_beat", arg_beat_a, 0);
`endif
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (rstn && en_b && out_valid_b) begin
         if (q_b.size() == 0) begin
            check("b_spurious_valid", out_valid_b, 0);
         end else begin
            e = q_b.pop_front();
            check("b_min_out",  min_out_b,  e.mn);
            check("b_beat_cnt", beat_cnt_b, e.cnt);
            check("b_out_ovf",  out_ovf_b,  e.ovf);
            check("b_latency",  ecnt_b,     e.at);
`ifdef CBFP_MIN_ARGMIN_EN
            check("b_arg_lane", arg_lane_b, e.lane);
            check("b_arg_beat", arg_beat_b, e.beat);
`else
            check("b_arg_lane", arg_lane_b, 0);
            check("b_arg_beat", arg_beat_b, 0);
`endif
         end
      end
   end

   task automatic drive_a(input logic v, input logic l, input logic e);
      @(negedge clk);
      en_a = e; in_valid_a = v; in_last_a = l; min_a = lanes_a;
   endtask

   // Called in the same timestep as the drive_a() of the closing beat.
   task automatic expect_a(input int mn, input int cnt, input int ovf, input int lane, input int beat);
      exp_t e;
      e.mn = mn; e.cnt = cnt; e.ovf = ovf; e.lane = lane; e.beat = beat;
      e.at = ecnt_a + 1 + TA;
      q_a.push_back(e);
   endtask

   task automatic drive_b(input logic v, input logic l);
      @(negedge clk);
      in_valid_b = v; in_last_b = l; min_b = lanes_b;
   endtask

   task automatic expect_b(input int mn, input int cnt, input int ovf, input int lane, input int beat);
      exp_t e;
      e.mn = mn; e.cnt = cnt; e.ovf = ovf; e.lane = lane; e.beat = beat;
      e.at = ecnt_b + 1 + TB;
      q_b.push_back(e);
   endtask

   task automatic check_a_zero(input string phase);
      check({phase, "_out_valid"}, out_valid_a, 0);
      check({phase, "_min_out"},   min_out_a,   0);
      check({phase, "_beat_cnt"},  beat_cnt_a,  0);
      check({phase, "_out_ovf"},   out_ovf_a,   0);
      check({phase, "_arg_lane"},  arg_lane_a,  0);
      check({phase, "_arg_beat"},  arg_beat_a,  0);
   endtask

   initial begin
      int target, cnt, mn, lane, beat, bmin, blane;
      logic last;

      en_a = 1'b1; in_valid_a = 1'b0; in_last_a = 1'b0;
      lanes_a = '{default: 5'd0}; min_a = lanes_a;
      en_b = 1'b1; in_valid_b = 1'b0; in_last_b = 1'b0;
      lanes_b = '{default: 5'd0}; min_b = lanes_b;

      // Reset state
      #2;
      check_a_zero("rst0_a");
      check("rst0_b_out_valid", out_valid_b, 0);
      check("rst0_b_min_out",   min_out_b,   0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;

      // Single-beat block; two lanes share the minimum, lower lane wins
      lanes_a = '{5'd9, 5'd7, 5'd12, 5'd3, 5'd5, 5'd3, 5'd20, 5'd31};
      drive_a(1, 1, 1); expect_a(3, 1, 0, 3, 0);

      // Two-beat block
      lanes_a = '{default: 5'd10};
      drive_a(1, 0, 1);
      lanes_a[6] = 5'd4;
      drive_a(1, 1, 1); expect_a(4, 2, 0, 6, 1);

      // Back-to-back single-beat blocks: consecutive pulses
      lanes_a = '{default: 5'd31}; lanes_a[7] = 5'd0;
      drive_a(1, 1, 1); expect_a(0, 1, 0, 7, 0);
      lanes_a = '{default: 5'd5};
      drive_a(1, 1, 1); expect_a(5, 1, 0, 0, 0);

      // Forced close at MAX_BEATS=4; a later tie does not displace beat 2
      lanes_a = '{default: 5'd9};
      drive_a(1, 0, 1);
      lanes_a[1] = 5'd6;
      drive_a(1, 0, 1);
      lanes_a = '{default: 5'd9}; lanes_a[5] = 5'd2;
      drive_a(1, 0, 1);
      lanes_a = '{default: 5'd9}; lanes_a[0] = 5'd2;
      drive_a(1, 0, 1); expect_a(2, 4, 1, 5, 2);
      lanes_a = '{default: 5'd8};
      drive_a(1, 1, 1); expect_a(8, 1, 0, 0, 0);

      // in_last on exactly the MAX_BEATS-th beat: normal close, no overflow
      lanes_a = '{default: 5'd6}; lanes_a[2] = 5'd1;
      drive_a(1, 0, 1);
      lanes_a = '{default: 5'd6};
      drive_a(1, 0, 1);
      drive_a(1, 0, 1);
      lanes_a[3] = 5'd1;
      drive_a(1, 1, 1); expect_a(1, 4, 0, 2, 0);

      // Bubbles and a 3-cycle stall mid-block (beat held on the bus while en=0)
      lanes_a = '{default: 5'd12}; lanes_a[4] = 5'd7;
      drive_a(1, 0, 1);
      drive_a(0, 0, 1);
      lanes_a = '{default: 5'd7};
      repeat (3) drive_a(1, 0, 0);
      drive_a(1, 0, 1);
      lanes_a = '{default: 5'd15}; lanes_a[3] = 5'd11;
      drive_a(1, 1, 1); expect_a(7, 3, 0, 4, 0);
      lanes_a = '{default: 5'd0};
      drive_a(0, 0, 1);
      // out_valid is now high; stall and confirm it and the result are held
      for (int i = 0; i < 3; i++) begin
         drive_a(0, 0, 0);
         #1;
         check("a_stall_valid_hold", out_valid_a, 1);
         check("a_stall_min_hold",   min_out_a,   7);
      end
      drive_a(0, 0, 1);
      drive_a(0, 0, 1);

      // Reset in the middle of a block
      lanes_a = '{default: 5'd1};
      drive_a(1, 0, 1);
      drive_a(0, 0, 1);
      #1 rstn = 1'b0;
      #1;
      check_a_zero("rst1_a");
      drive_a(0, 0, 1);
      rstn = 1'b1;
      lanes_a = '{default: 5'd20}; lanes_a[3] = 5'd18;
      drive_a(1, 1, 1); expect_a(18, 1, 0, 3, 0);
      repeat (4) drive_a(0, 0, 1);

      // Random back-to-back blocks on dut_b against a running-minimum model
      for (int blk = 0; blk < 40; blk++) begin
         target = int'($urandom_range(1, 20));
         cnt = 0; mn = 99; lane = 0; beat = 0;
         while (1) begin
            for (int j = 0; j < NB; j++) lanes_b[j] = 5'($urandom_range(2, 20));
            if ($urandom_range(0, 4) == 0) begin
               drive_b(0, 1'($urandom_range(0, 1)));
               continue;
            end
            bmin = 99; blane = 0;
            for (int j = 0; j < NB; j++) begin
               if (int'(lanes_b[j]) < bmin) begin
                  bmin = int'(lanes_b[j]);
                  blane = j;
               end
            end
            last = ((cnt + 1) == target);
            drive_b(1, last);
            if (bmin < mn) begin
               mn = bmin; lane = blane; beat = cnt;
            end
            cnt++;
            if (last || cnt == MAXB) begin
               expect_b(mn, cnt, last ? 0 : 1, lane, beat);
               break;
            end
         end
      end
      repeat (8) drive_b(0, 0);

      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
